// File: rtl/pfb_cfg_seq.sv
// Config/GSR sequencer for a dff_slice bank: loads one 10-bit word per slice, holds GSR, then releases.
// Optional readback register built when PFB_CFG_READBACK_EN is defined.
module pfb_cfg_seq #(
   parameter  int NSLICE   = 4,
   parameter  int GSR_HOLD = 8,
   localparam int IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1,
   localparam int CW       = (GSR_HOLD > 1) ? $clog2(GSR_HOLD) : 1
) (
   input  logic                 clk,
   input  logic                 gsrn,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [9:0]           cfg_wdata,
   output logic [NSLICE*10-1:0] cfg_bus,
   output logic                 slice_gsrn,
   output logic                 slice_gsrforce_n,
   output logic                 busy,
   output logic                 done,
   output logic                 restart_err,
   input  logic [IW-1:0]        rb_sel,
   output logic [9:0]           rb_data
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

   state_t                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     expired_q, expired_d;
   logic [NSLICE-1:0][9:0]   bus_q, bus_d;
   logic                     ready_q, ready_d;
   logic                     gsr_q, gsr_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     rerr_q, rerr_d;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      expired_d = expired_q;
      bus_d     = bus_q;
      rerr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (cfg_start) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (cfg_valid) begin
               bus_d[idx_q] = cfg_wdata;
               if (idx_q == IW'(NSLICE - 1)) begin
                  idx_d     = '0;
                  state_d   = S_HOLD;
                  cnt_d     = CW'(GSR_HOLD - 1);
                  expired_d = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            // A restart still commits this cycle's word but overrides the move to HOLD.
            if (cfg_start) begin
               idx_d   = '0;
               rerr_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_HOLD: begin
            // Counter reaching 0 arms the exit; the move to RUN happens one cycle later.
            if (expired_q)          state_d   = S_RUN;
            else if (cnt_q == '0)   expired_d = 1'b1;
            else                    cnt_d     = cnt_q - CW'(1);
         end
         default: begin
            if (cfg_start) state_d = S_LOAD;
         end
      endcase
      ready_d = (state_d == S_LOAD);
      busy_d  = (state_d == S_LOAD) || (state_d == S_HOLD);
      done_d  = (state_d == S_RUN);
      gsr_d   = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge gsrn) begin
      if (!gsrn) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         expired_q <= 1'b0;
         bus_q     <= '0;
         ready_q   <= 1'b0;
         gsr_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
         bus_q     <= bus_d;
         ready_q   <= ready_d;
         gsr_q     <= gsr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rerr_q    <= rerr_d;
      end
   end

   assign cfg_bus          = bus_q;
   assign cfg_ready        = ready_q;
   assign slice_gsrn       = gsr_q;
   assign slice_gsrforce_n = gsr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign restart_err      = rerr_q;

`ifdef PFB_CFG_READBACK_EN
   logic [9:0] rb_data_q, rb_data_d;

   always_comb begin
      rb_data_d = '0;
      if (32'(rb_sel) < NSLICE) rb_data_d = bus_q[rb_sel];
   end

   always_ff @(posedge clk or negedge gsrn) begin
      if (!gsrn) rb_data_q <= '0;
      else       rb_data_q <= rb_data_d;
   end

   assign rb_data = rb_data_q;
`else
   logic unused_rb_sel;
   assign unused_rb_sel = ^rb_sel;
   assign rb_data       = '0;
`endif

endmodule

// File: tb/tb_pfb_cfg_seq.sv
// Directed bench for pfb_cfg_seq (NSLICE=4, GSR_HOLD=8) with hand-computed expectations.
module tb_pfb_cfg_seq;

   logic        clk = 1'b0;
   logic        gsrn;
   logic        cfg_start, cfg_valid;
   logic        cfg_ready;
   logic [9:0]  cfg_wdata;
   logic [39:0] cfg_bus;
   logic        slice_gsrn, slice_gsrforce_n, busy, done, restart_err;
   logic [1:0]  rb_sel;
   logic [9:0]  rb_data;

   int total = 0;
   int bad   = 0;

   pfb_cfg_seq #(.NSLICE(4), .GSR_HOLD(8)) dut (
      .clk(clk), .gsrn(gsrn), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_wdata(cfg_wdata), .cfg_bus(cfg_bus),
      .slice_gsrn(slice_gsrn), .slice_gsrforce_n(slice_gsrforce_n),
      .busy(busy), .done(done), .restart_err(restart_err),
      .rb_sel(rb_sel), .rb_data(rb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [9:0] w);
      cfg_valid = 1'b1;
      cfg_wdata = w;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic run_hold(input string tag);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk({tag, "_hold_gsrn"}, 64'(slice_gsrn), 64'd0);
         chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
      end
      tick();
      chk({tag, "_run_gsrn"},  64'(slice_gsrn), 64'd1);
      chk({tag, "_run_force"}, 64'(slice_gsrforce_n), 64'd1);
      chk({tag, "_run_done"},  64'(done), 64'd1);
      chk({tag, "_run_busy"},  64'(busy), 64'd0);
   endtask

   logic [9:0] rb_exp;

   initial begin
      gsrn = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_wdata = '0; rb_sel = '0;

      // reset hold with random inputs
      for (int i = 0; i < 4; i++) begin
         cfg_start = 1'($urandom); cfg_valid = 1'($urandom);
         cfg_wdata = 10'($urandom); rb_sel = 2'($urandom);
         tick();
      end
      chk("rst_bus",   64'(cfg_bus), 64'd0);
      chk("rst_gsrn",  64'(slice_gsrn), 64'd0);
      chk("rst_force", 64'(slice_gsrforce_n), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_ready", 64'(cfg_ready), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_rb",    64'(rb_data), 64'd0);
      cfg_start = 1'b0; cfg_valid = 1'b0; rb_sel = '0;
      @(negedge clk); gsrn = 1'b1;
      tick();
      chk("idle_valid_ignored", 64'(cfg_bus), 64'd0);

      // nominal load
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("nom_ready", 64'(cfg_ready), 64'd1);
      chk("nom_busy",  64'(busy), 64'd1);
      word(10'h3A5);
      chk("nom_slot0", 64'(cfg_bus), 64'h3A5);
      word(10'h001);
      word(10'h2F0);
      word(10'h155);
      chk("nom_bus",    64'(cfg_bus), 64'({10'h155, 10'h2F0, 10'h001, 10'h3A5}));
      chk("nom_ready0", 64'(cfg_ready), 64'd0);
      chk("nom_gsrn0",  64'(slice_gsrn), 64'd0);
      run_hold("nom");
      chk("nom_bus_run", 64'(cfg_bus), 64'({10'h155, 10'h2F0, 10'h001, 10'h3A5}));

      // readback of slot 2
      rb_sel = 2'd2; tick();
`ifdef PFB_CFG_READBACK_EN
      rb_exp = 10'h2F0;
`else
      rb_exp = 10'h000;
`endif
      chk("rb_slot2", 64'(rb_data), 64'(rb_exp));

      // reconfig from RUN, valid gaps
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("rcfg_gsrn",  64'(slice_gsrn), 64'd0);
      chk("rcfg_done",  64'(done), 64'd0);
      chk("rcfg_busy",  64'(busy), 64'd1);
      chk("rcfg_ready", 64'(cfg_ready), 64'd1);
      chk("rcfg_keep",  64'(cfg_bus), 64'({10'h155, 10'h2F0, 10'h001, 10'h3A5}));
      word(10'h011); cfg_wdata = 10'h3FF; tick();
      word(10'h022); cfg_wdata = 10'h3FF; tick();
      word(10'h033); cfg_wdata = 10'h3FF; tick();
      chk("gap_bus3",   64'(cfg_bus), 64'({10'h155, 10'h033, 10'h022, 10'h011}));
      chk("gap_ready3", 64'(cfg_ready), 64'd1);
      word(10'h044);
      chk("gap_ready4", 64'(cfg_ready), 64'd0);
      chk("gap_bus",    64'(cfg_bus), 64'({10'h044, 10'h033, 10'h022, 10'h011}));
      run_hold("gap");

      // restart with the 2nd handshake
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      word(10'h101);
      cfg_start = 1'b1; word(10'h202); cfg_start = 1'b0;
      chk("rst_err_pulse", 64'(restart_err), 64'd1);
      chk("rst_slot1",     64'(cfg_bus[19:0]), 64'({10'h202, 10'h101}));
      chk("rst_ready",     64'(cfg_ready), 64'd1);
      word(10'h303);
      chk("rst_err_clear", 64'(restart_err), 64'd0);
      word(10'h304);
      word(10'h305);
      chk("rst_still_load", 64'(cfg_ready), 64'd1);
      word(10'h306);
      chk("rst_bus",   64'(cfg_bus), 64'({10'h306, 10'h305, 10'h304, 10'h303}));
      chk("rst_hold",  64'(cfg_ready), 64'd0);
      chk("rst_busyh", 64'(busy), 64'd1);

      // reset pulse in HOLD cycle 3
      tick(); tick(); tick();
      #2 gsrn = 1'b0;
      #1;
      chk("mrst_bus",  64'(cfg_bus), 64'd0);
      chk("mrst_gsrn", 64'(slice_gsrn), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      @(negedge clk); gsrn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mrst_no_run", 64'(done | slice_gsrn | busy), 64'd0);
      end
      chk("mrst_bus_end", 64'(cfg_bus), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
